// File: rtl/img_pkg.sv
// Shared definitions for the image-sensor capture path: bus widths, default
// exposure thresholds and the capture FSM encoding.
package img_pkg;

   localparam int PixelWidth = 12;
   localparam int WordWidth  = 16;

   localparam logic [PixelWidth-1:0] DefaultHighlightThresh = 12'hFF0;
   localparam logic [PixelWidth-1:0] DefaultShadowThresh    = 12'h00F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FV_LOW,
      ST_WAIT_FV_HIGH,
      ST_CAPTURE,
      ST_DONE
   } cap_state_t;

   function automatic logic [WordWidth-1:0] pixel_to_word(input logic [PixelWidth-1:0] pix);
      return {{(WordWidth-PixelWidth){1'b0}}, pix};
   endfunction

endpackage

// File: rtl/img_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; when empty the
// read port keeps presenting the last word popped.
module img_fifo #(
   parameter int Depth = 8,
   parameter int Width = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   localparam int AddrWidth = $clog2(Depth);
   localparam logic [AddrWidth:0]   FullCount = (AddrWidth+1)'(Depth);
   localparam logic [AddrWidth:0]   CountOne  = (AddrWidth+1)'(1);
   localparam logic [AddrWidth-1:0] PtrOne    = AddrWidth'(1);

   logic [Width-1:0]     mem [Depth];
   logic [AddrWidth-1:0] wr_ptr;
   logic [AddrWidth-1:0] rd_ptr;
   logic [AddrWidth:0]   count;
   logic [Width-1:0]     last_data;
   logic                 do_push;
   logic                 do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FullCount);
   assign do_pop   = pop && !empty;
   // A full FIFO still takes a word when the same cycle frees a slot.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? last_data : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_data <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PtrOne;
         end
         if (do_pop) begin
            rd_ptr    <= rd_ptr + PtrOne;
            last_data <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CountOne;
            2'b01:   count <= count - CountOne;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/img_capture_stats.sv
// Sensor receive stage: registers the parallel pixel bus, captures one whole
// frame per trigger into the output FIFO and gathers auto-exposure statistics.
module img_capture_stats
   import img_pkg::*;
#(
   parameter int                    FifoDepth       = 8,
   parameter logic [PixelWidth-1:0] HighlightThresh = DefaultHighlightThresh,
   parameter logic [PixelWidth-1:0] ShadowThresh    = DefaultShadowThresh,
   parameter int                    CountWidth      = 18
) (
   input  logic                  img_dclk,
   input  logic                  rst_,
   input  logic [PixelWidth-1:0] img_d,
   input  logic                  img_fv,
   input  logic                  img_lv,
   input  logic                  ctrl_trigger,
   output logic [WordWidth-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  status_capturing,
   output logic                  status_done,
   output logic                  status_overflow,
   output logic [CountWidth-1:0] status_pixel_count,
   output logic [CountWidth-1:0] status_row_count,
   output logic [CountWidth-1:0] status_highlight_count,
   output logic [CountWidth-1:0] status_shadow_count
);

   localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

   function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] value,
                                                      input logic en);
      return (en && (value != '1)) ? value + CountOne : value;
   endfunction

   logic [PixelWidth-1:0] d_s1;
   logic                  fv_s1;
   logic                  lv_s1;
   logic                  fv_s2;
   logic                  lv_s2;

   cap_state_t state;
   cap_state_t state_next;

   logic                 trig_accept;
   logic                 fv_rise;
   logic                 fv_fall;
   logic                 in_frame;
   logic                 pix_now;
   logic                 row_now;
   logic                 hl_now;
   logic                 sh_now;
   logic                 push_valid;
   logic [WordWidth-1:0] push_data;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 fifo_pop;
   logic                 drop;

   always_ff @(posedge img_dclk) begin
      if (!rst_) begin
         d_s1  <= '0;
         fv_s1 <= 1'b0;
         lv_s1 <= 1'b0;
         fv_s2 <= 1'b0;
         lv_s2 <= 1'b0;
      end else begin
         d_s1  <= img_d;
         fv_s1 <= img_fv;
         lv_s1 <= img_lv;
         fv_s2 <= fv_s1;
         lv_s2 <= lv_s1;
      end
   end

   assign trig_accept = ctrl_trigger && ((state == ST_IDLE) || (state == ST_DONE));
   assign fv_rise     = fv_s1 && !fv_s2;
   assign fv_fall     = !fv_s1 && fv_s2;
   // The fv-rise cycle already carries a pixel if lv rose with fv.
   assign in_frame    = (state == ST_CAPTURE) || ((state == ST_WAIT_FV_HIGH) && fv_rise);
   assign pix_now     = in_frame && fv_s1 && lv_s1;
   assign row_now     = (state == ST_CAPTURE) && lv_s2 && (!lv_s1 || fv_fall);
   assign hl_now      = pix_now && (d_s1 >= HighlightThresh);
   assign sh_now      = pix_now && (d_s1 <= ShadowThresh);

   always_ff @(posedge img_dclk) begin
      if (!rst_) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      status_capturing = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (ctrl_trigger) state_next = ST_WAIT_FV_LOW;
         end
         ST_WAIT_FV_LOW: begin
            status_capturing = 1'b1;
            if (!fv_s1) state_next = ST_WAIT_FV_HIGH;
         end
         ST_WAIT_FV_HIGH: begin
            status_capturing = 1'b1;
            if (fv_rise) state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            status_capturing = 1'b1;
            if (fv_fall) state_next = ST_DONE;
         end
         ST_DONE: begin
            if (ctrl_trigger) state_next = ST_WAIT_FV_LOW;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge img_dclk) begin
      if (!rst_) begin
         status_pixel_count     <= '0;
         status_row_count       <= '0;
         status_highlight_count <= '0;
         status_shadow_count    <= '0;
      end else if (trig_accept) begin
         status_pixel_count     <= '0;
         status_row_count       <= '0;
         status_highlight_count <= '0;
         status_shadow_count    <= '0;
      end else begin
         status_pixel_count     <= sat_inc(status_pixel_count, pix_now);
         status_row_count       <= sat_inc(status_row_count, row_now);
         status_highlight_count <= sat_inc(status_highlight_count, hl_now);
         status_shadow_count    <= sat_inc(status_shadow_count, sh_now);
      end
   end

   always_ff @(posedge img_dclk) begin
      if (!rst_) begin
         push_valid <= 1'b0;
         push_data  <= '0;
      end else begin
         push_valid <= pix_now;
         push_data  <= pixel_to_word(d_s1);
      end
   end

   assign fifo_pop  = out_valid && out_ready;
   assign drop      = push_valid && fifo_full && !fifo_pop;
   assign out_valid = !fifo_empty;

   always_ff @(posedge img_dclk) begin
      if (!rst_) begin
         status_done     <= 1'b0;
         status_overflow <= 1'b0;
      end else if (trig_accept) begin
         status_done     <= 1'b0;
         status_overflow <= 1'b0;
      end else begin
         if (state == ST_DONE) status_done <= 1'b1;
         if (drop) status_overflow <= 1'b1;
      end
   end

   img_fifo #(
      .Depth (FifoDepth),
      .Width (WordWidth)
   ) u_fifo (
      .clk       (img_dclk),
      .rst_      (rst_),
      .push      (push_valid),
      .push_data (push_data),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_img_capture_stats.sv
// Directed bench for img_capture_stats using a small 8x8 sensor model; a second
// instance with narrow counters exercises saturation on the same stimulus.
module tb_img_capture_stats;
   import img_pkg::*;

   localparam int Cols   = 8;
   localparam int Rows   = 8;
   localparam int HBlank = 4;
   localparam int VBlank = 16;

   logic                  img_dclk = 1'b0;
   logic                  rst_;
   logic [PixelWidth-1:0] img_d;
   logic                  img_fv;
   logic                  img_lv;
   logic                  ctrl_trigger;
   logic                  out_ready;

   logic [WordWidth-1:0]  out_data;
   logic                  out_valid;
   logic                  status_capturing;
   logic                  status_done;
   logic                  status_overflow;
   logic [17:0]           status_pixel_count;
   logic [17:0]           status_row_count;
   logic [17:0]           status_highlight_count;
   logic [17:0]           status_shadow_count;

   logic [WordWidth-1:0]  sat_out_data;
   logic                  sat_out_valid;
   logic                  sat_capturing;
   logic                  sat_done;
   logic                  sat_overflow;
   logic [4:0]            sat_pixel_count;
   logic [4:0]            sat_row_count;
   logic [4:0]            sat_highlight_count;
   logic [4:0]            sat_shadow_count;

   int n_checks = 0;
   int n_fail   = 0;
   int word_idx = 0;
   int exp_mode = 0;

   always #5 img_dclk = ~img_dclk;

   img_capture_stats dut (
      .img_dclk               (img_dclk),
      .rst_                   (rst_),
      .img_d                  (img_d),
      .img_fv                 (img_fv),
      .img_lv                 (img_lv),
      .ctrl_trigger           (ctrl_trigger),
      .out_data               (out_data),
      .out_valid              (out_valid),
      .out_ready              (out_ready),
      .status_capturing       (status_capturing),
      .status_done            (status_done),
      .status_overflow        (status_overflow),
      .status_pixel_count     (status_pixel_count),
      .status_row_count       (status_row_count),
      .status_highlight_count (status_highlight_count),
      .status_shadow_count    (status_shadow_count)
   );

   img_capture_stats #(.CountWidth(5)) dut_sat (
      .img_dclk               (img_dclk),
      .rst_                   (rst_),
      .img_d                  (img_d),
      .img_fv                 (img_fv),
      .img_lv                 (img_lv),
      .ctrl_trigger           (ctrl_trigger),
      .out_data               (sat_out_data),
      .out_valid              (sat_out_valid),
      .out_ready              (1'b1),
      .status_capturing       (sat_capturing),
      .status_done            (sat_done),
      .status_overflow        (sat_overflow),
      .status_pixel_count     (sat_pixel_count),
      .status_row_count       (sat_row_count),
      .status_highlight_count (sat_highlight_count),
      .status_shadow_count    (sat_shadow_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [PixelWidth-1:0] pix_model(input int mode, input int r, input int c);
      if (mode == 0) return ((r % 4 == 0) && (c % 4 == 0)) ? 12'hFFF : 12'h000;
      case (c % 4)
         0:       return 12'hFF0;
         1:       return 12'hFEF;
         2:       return 12'h00F;
         default: return 12'h010;
      endcase
   endfunction

   // Every accepted word must match the sensor model in raster order.
   always @(negedge img_dclk) begin
      #2;
      if (rst_ && out_valid && out_ready) begin
         checkOutput("word", 32'({4'b0, pix_model(exp_mode, word_idx / Cols, word_idx % Cols)}),
                     32'(out_data));
         word_idx++;
      end
   end

   task automatic applyStimulus(input int mode, input bit pre_trig,
                                input logic [7:0] trig_rows, input int rst_row);
      exp_mode = mode;
      img_fv = 1'b0;
      img_lv = 1'b0;
      img_d  = '0;
      for (int i = 0; i < VBlank; i++) begin
         ctrl_trigger = pre_trig && (i == 4);
         @(negedge img_dclk);
      end
      ctrl_trigger = 1'b0;
      img_fv = 1'b1;
      repeat (2) @(negedge img_dclk);
      for (int r = 0; r < Rows; r++) begin
         if (trig_rows[r]) begin
            ctrl_trigger = 1'b1;
            @(negedge img_dclk);
            ctrl_trigger = 1'b0;
         end
         if (r == rst_row) begin
            rst_ = 1'b0;
            @(negedge img_dclk);
            rst_ = 1'b1;
            checkOutput("rst_pixel", 32'(status_pixel_count), 0);
            checkOutput("rst_row", 32'(status_row_count), 0);
            checkOutput("rst_done", 32'(status_done), 0);
            checkOutput("rst_capturing", 32'(status_capturing), 0);
            checkOutput("rst_valid", 32'(out_valid), 0);
         end
         img_lv = 1'b1;
         for (int c = 0; c < Cols; c++) begin
            img_d = pix_model(mode, r, c);
            @(negedge img_dclk);
         end
         img_lv = 1'b0;
         img_d  = '0;
         repeat (HBlank) @(negedge img_dclk);
      end
      img_fv = 1'b0;
      repeat (6) @(negedge img_dclk);
   endtask

   task automatic check_frame(input int pix, input int rows, input int hl, input int sh,
                              input int words);
      checkOutput("pixel_count", 32'(status_pixel_count), pix);
      checkOutput("row_count", 32'(status_row_count), rows);
      checkOutput("highlight_count", 32'(status_highlight_count), hl);
      checkOutput("shadow_count", 32'(status_shadow_count), sh);
      checkOutput("done", 32'(status_done), 1);
      checkOutput("capturing_after", 32'(status_capturing), 0);
      checkOutput("words_out", word_idx, words);
   endtask

   task automatic check_sat();
      checkOutput("sat_pixel", 32'(sat_pixel_count), 31);
      checkOutput("sat_row", 32'(sat_row_count), 8);
      checkOutput("sat_highlight", 32'(sat_highlight_count), 4);
      checkOutput("sat_shadow", 32'(sat_shadow_count), 31);
   endtask

   task automatic drain_fifo();
      int n;
      n = 0;
      while (out_valid && n < 200) begin
         @(negedge img_dclk);
         n++;
      end
      checkOutput("drain_timeout", 32'(out_valid), 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time %0t reached, expected finish before %0t", $time, 100000);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_         = 1'b0;
      img_d        = '0;
      img_fv       = 1'b0;
      img_lv       = 1'b0;
      ctrl_trigger = 1'b0;
      out_ready    = 1'b1;
      repeat (3) @(negedge img_dclk);
      checkOutput("reset_valid", 32'(out_valid), 0);
      checkOutput("reset_data", 32'(out_data), 0);
      checkOutput("reset_capturing", 32'(status_capturing), 0);
      checkOutput("reset_done", 32'(status_done), 0);
      checkOutput("reset_overflow", 32'(status_overflow), 0);
      checkOutput("reset_pixel", 32'(status_pixel_count), 0);
      checkOutput("reset_row", 32'(status_row_count), 0);
      checkOutput("reset_highlight", 32'(status_highlight_count), 0);
      checkOutput("reset_shadow", 32'(status_shadow_count), 0);
      rst_ = 1'b1;
      repeat (2) @(negedge img_dclk);
      checkOutput("idle_capturing", 32'(status_capturing), 0);

      $display("[TB] baseline frame, trigger in blanking");
      word_idx = 0;
      applyStimulus(0, 1'b1, 8'h00, -1);
      check_frame(64, 8, 4, 60, 64);
      checkOutput("overflow_clean", 32'(status_overflow), 0);
      check_sat();

      $display("[TB] threshold boundary frame");
      word_idx = 0;
      applyStimulus(1, 1'b1, 8'h00, -1);
      check_frame(64, 8, 16, 16, 64);

      $display("[TB] trigger mid-frame");
      word_idx = 0;
      applyStimulus(0, 1'b0, 8'b0000_1000, -1);
      checkOutput("skip_done", 32'(status_done), 0);
      checkOutput("skip_pixel", 32'(status_pixel_count), 0);
      checkOutput("skip_capturing", 32'(status_capturing), 1);
      checkOutput("skip_words", word_idx, 0);
      applyStimulus(0, 1'b0, 8'h00, -1);
      check_frame(64, 8, 4, 60, 64);

      $display("[TB] triggers during capture");
      word_idx = 0;
      applyStimulus(0, 1'b1, 8'b0010_0001, -1);
      check_frame(64, 8, 4, 60, 64);

      $display("[TB] consumer stalled for whole frame");
      out_ready = 1'b0;
      word_idx  = 0;
      applyStimulus(0, 1'b1, 8'h00, -1);
      checkOutput("ovf_flag", 32'(status_overflow), 1);
      checkOutput("ovf_pixel", 32'(status_pixel_count), 64);
      checkOutput("ovf_highlight", 32'(status_highlight_count), 4);
      checkOutput("ovf_valid", 32'(out_valid), 1);
      checkOutput("ovf_head", 32'(out_data), 32'h0FFF);
      out_ready = 1'b1;
      drain_fifo();
      checkOutput("ovf_words", word_idx, 8);
      ctrl_trigger = 1'b1;
      @(negedge img_dclk);
      ctrl_trigger = 1'b0;
      checkOutput("trig_clr_overflow", 32'(status_overflow), 0);
      checkOutput("trig_clr_done", 32'(status_done), 0);
      checkOutput("trig_clr_pixel", 32'(status_pixel_count), 0);
      checkOutput("trig_capturing", 32'(status_capturing), 1);

      $display("[TB] reset mid-frame then re-trigger");
      word_idx = 0;
      applyStimulus(0, 1'b0, 8'h00, 2);
      checkOutput("post_rst_done", 32'(status_done), 0);
      checkOutput("post_rst_pixel", 32'(status_pixel_count), 0);
      checkOutput("post_rst_capturing", 32'(status_capturing), 0);
      word_idx = 0;
      applyStimulus(0, 1'b1, 8'h00, -1);
      check_frame(64, 8, 4, 60, 64);
      check_sat();

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
